// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the TX path and the upcoming RX.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction
endpackage

// File: rtl/uart_tx_framed_if.sv
// Upstream word handshake plus serial-side status of the framed UART transmitter.
interface uart_tx_framed_if #(parameter int DATA_WIDTH = 8);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  tx;
  logic                  busy;
  logic                  frame_done;

  modport master (output in_valid, in_data, input in_ready, tx, busy, frame_done);
  modport slave  (input in_valid, in_data, output in_ready, tx, busy, frame_done);
endinterface

// File: rtl/uart_baud_gen.sv
// Clock-enable bit timer: counts 0..CLKS_PER_BIT-1 while enabled, held at 0 otherwise.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic areset_n,
  input  logic clear,
  input  logic en,
  output logic bit_tick,
  output logic pre_tick
);
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = en && (cnt_q == LAST);
  // One cycle ahead of bit_tick, so a registered output can line up with it.
  assign pre_tick = en && (cnt_q == PRE);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || !en || bit_tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: start, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 1_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input logic clk,
  input logic areset_n,
  uart_tx_framed_if.slave bus
);
  localparam int CPB = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (CPB < 2) begin : g_err_cpb
    $error("uart_tx_framed: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_err_dw
    $error("uart_tx_framed: DATA_WIDTH must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_err_par
    $error("uart_tx_framed: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
    $error("uart_tx_framed: STOP_BITS must be 1 or 2");
  end

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [3:0]            idx_q, idx_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  bit_tick, pre_tick, hs;

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign hs             = bus.in_valid && bus.in_ready;

  uart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk      (clk),
    .areset_n (areset_n),
    .clear    (hs),
    .en       (state_q != IDLE),
    .bit_tick (bit_tick),
    .pre_tick (pre_tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (hs) begin
        state_d = START;
        shift_d = bus.in_data;
        par_d   = (PARITY_MODE == PARITY_ODD) ? ~^bus.in_data : ^bus.in_data;
        idx_d   = '0;
        tx_d    = 1'b0;
      end
      START: if (bit_tick) begin
        state_d = DATA;
        tx_d    = shift_q[0];
      end
      DATA: if (bit_tick) begin
        if (idx_q == LAST_DATA) begin
          idx_d = '0;
          if (PARITY_MODE != PARITY_NONE) begin
            state_d = PARITY;
            tx_d    = par_q;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end else begin
          idx_d   = idx_q + 4'd1;
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
      PARITY: if (bit_tick) begin
        state_d = STOP;
        tx_d    = 1'b1;
      end
      STOP: begin
        // Registered pulse must cover the cycle that ends on the final tick.
        done_d = pre_tick && (idx_q == LAST_STOP);
        if (bit_tick) begin
          if (idx_q == LAST_STOP) state_d = IDLE;
          else                    idx_d   = idx_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: 8N1, 8E1, 8O1 and 8N2 instances at 16 clocks per bit.
module tb_uart_tx_framed;
  logic       clk = 1'b0;
  logic       areset_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] sel = 2'd0;
  logic       o_tx, o_busy, o_rdy, o_done;
  int         total = 0, bad = 0, pos = 0, done_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_framed_if #(.DATA_WIDTH(8)) if_n1 ();
  uart_tx_framed_if #(.DATA_WIDTH(8)) if_e1 ();
  uart_tx_framed_if #(.DATA_WIDTH(8)) if_o1 ();
  uart_tx_framed_if #(.DATA_WIDTH(8)) if_n2 ();

  assign if_n1.in_valid = valid && (sel == 2'd0);
  assign if_e1.in_valid = valid && (sel == 2'd1);
  assign if_o1.in_valid = valid && (sel == 2'd2);
  assign if_n2.in_valid = valid && (sel == 2'd3);
  assign if_n1.in_data = data;
  assign if_e1.in_data = data;
  assign if_o1.in_data = data;
  assign if_n2.in_data = data;

  uart_tx_framed #(.SYS_CLK_FREQ(160), .BAUD_RATE(10), .PARITY_MODE(0), .STOP_BITS(1))
    u_n1 (.clk(clk), .areset_n(areset_n), .bus(if_n1));
  uart_tx_framed #(.SYS_CLK_FREQ(160), .BAUD_RATE(10), .PARITY_MODE(1), .STOP_BITS(1))
    u_e1 (.clk(clk), .areset_n(areset_n), .bus(if_e1));
  uart_tx_framed #(.SYS_CLK_FREQ(160), .BAUD_RATE(10), .PARITY_MODE(2), .STOP_BITS(1))
    u_o1 (.clk(clk), .areset_n(areset_n), .bus(if_o1));
  uart_tx_framed #(.SYS_CLK_FREQ(160), .BAUD_RATE(10), .PARITY_MODE(0), .STOP_BITS(2))
    u_n2 (.clk(clk), .areset_n(areset_n), .bus(if_n2));

  always_comb begin
    case (sel)
      2'd0:    {o_tx, o_busy, o_rdy, o_done} = {if_n1.tx, if_n1.busy, if_n1.in_ready, if_n1.frame_done};
      2'd1:    {o_tx, o_busy, o_rdy, o_done} = {if_e1.tx, if_e1.busy, if_e1.in_ready, if_e1.frame_done};
      2'd2:    {o_tx, o_busy, o_rdy, o_done} = {if_o1.tx, if_o1.busy, if_o1.in_ready, if_o1.frame_done};
      default: {o_tx, o_busy, o_rdy, o_done} = {if_n2.tx, if_n2.busy, if_n2.in_ready, if_n2.frame_done};
    endcase
  end

  always @(negedge clk) if (o_done === 1'b1) done_cnt++;

  // Frame tables: bits are {.., stop, [parity], data, start}, bit k at index k.
  localparam logic [7:0]  TDAT [4] = '{8'hA5, 8'h07, 8'h07, 8'h00};
  localparam int          TF   [4] = '{10, 11, 11, 11};
  localparam int          TSS  [4] = '{144, 160, 160, 144};
  localparam logic [11:0] TEXP [4] = '{{2'b00, 1'b1, 8'hA5, 1'b0},
                                       {1'b0, 1'b1, 1'b1, 8'h07, 1'b0},
                                       {1'b0, 1'b1, 1'b0, 8'h07, 1'b0},
                                       {1'b0, 2'b11, 8'h00, 1'b0}};

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
    pos += n;
  endtask

  task automatic go_to(input int p);
    if (p > pos) adv(p - pos);
  endtask

  // Handshake on the next edge (E0); afterwards pos counts cycles from E0.
  task automatic start_frame(input logic [7:0] d);
    data  = d;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    pos   = 0;
  endtask

  // Receiver model: sample mid-bit, and watch that the stop region stays high.
  task automatic capture(input int f, input int ss, output logic [11:0] b, output logic stop_hi);
    b = '0;
    stop_hi = 1'b1;
    for (int p = pos + 1; p < f * 16; p++) begin
      go_to(p);
      if (p % 16 == 8) b[p/16] = o_tx;
      if (p >= ss && o_tx !== 1'b1) stop_hi = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      total++;
      if ({o_tx, o_busy, o_rdy, o_done} !== 4'b1010) begin
        bad++;
        $display("FAIL reset_in sel=%0d got=%b want=1010", i, {o_tx, o_busy, o_rdy, o_done});
      end
    end
    @(posedge clk);
    #1;
    areset_n = 1'b1;
    adv(2);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      #1;
      total++;
      if ({o_tx, o_busy, o_rdy, o_done} !== 4'b1010) begin
        bad++;
        $display("FAIL reset_out sel=%0d got=%b want=1010", i, {o_tx, o_busy, o_rdy, o_done});
      end
    end
    sel = 2'd0;
    adv(1);
  endtask

  task automatic test_formats();
    logic [11:0] b;
    logic        hi;
    int          d0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      adv(2);
      d0 = done_cnt;
      start_frame(TDAT[i]);
      total++;
      if ({o_tx, o_busy, o_rdy} !== 3'b010) begin
        bad++;
        $display("FAIL fmt%0d_e0 got=%b want=010", i, {o_tx, o_busy, o_rdy});
      end
      capture(TF[i], TSS[i], b, hi);
      total++;
      if (b !== TEXP[i]) begin
        bad++;
        $display("FAIL fmt%0d_bits got=%h want=%h", i, b, TEXP[i]);
      end
      total++;
      if (hi !== 1'b1) begin
        bad++;
        $display("FAIL fmt%0d_stop_high got=%b want=1", i, hi);
      end
      total++;
      if ({o_done, o_rdy} !== 2'b10) begin
        bad++;
        $display("FAIL fmt%0d_done_last got=%b want=10", i, {o_done, o_rdy});
      end
      go_to(TF[i] * 16);
      total++;
      if ({o_done, o_rdy, o_busy, o_tx} !== 4'b0101) begin
        bad++;
        $display("FAIL fmt%0d_end got=%b want=0101", i, {o_done, o_rdy, o_busy, o_tx});
      end
      total++;
      if (done_cnt - d0 !== 1) begin
        bad++;
        $display("FAIL fmt%0d_done_count got=%0d want=1", i, done_cnt - d0);
      end
    end
    sel = 2'd0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] b;
    logic        hi;
    sel = 2'd0;
    adv(2);
    start_frame(8'h55);
    valid = 1'b1;
    adv(1);
    data = 8'hAA;
    capture(10, 144, b, hi);
    total++;
    if (b !== {2'b00, 1'b1, 8'h55, 1'b0}) begin
      bad++;
      $display("FAIL b2b_first got=%h want=%h", b, {2'b00, 1'b1, 8'h55, 1'b0});
    end
    go_to(160);
    total++;
    if ({o_tx, o_rdy, o_busy} !== 3'b110) begin
      bad++;
      $display("FAIL b2b_gap got=%b want=110", {o_tx, o_rdy, o_busy});
    end
    go_to(161);
    valid = 1'b0;
    total++;
    if ({o_tx, o_rdy, o_busy} !== 3'b001) begin
      bad++;
      $display("FAIL b2b_second_start got=%b want=001", {o_tx, o_rdy, o_busy});
    end
    pos = 0;
    capture(10, 144, b, hi);
    total++;
    if (b !== {2'b00, 1'b1, 8'hAA, 1'b0} || hi !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second got=%h/%b want=%h/1", b, hi, {2'b00, 1'b1, 8'hAA, 1'b0});
    end
    go_to(160);
  endtask

  task automatic test_ignore_busy();
    logic [11:0] b;
    logic        hi;
    int          d0;
    sel = 2'd0;
    adv(2);
    d0 = done_cnt;
    start_frame(8'h96);
    fork
      begin
        repeat (40) @(posedge clk);
        #1;
        data  = 8'hFF;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
      end
    join_none
    capture(10, 144, b, hi);
    total++;
    if (b !== {2'b00, 1'b1, 8'h96, 1'b0}) begin
      bad++;
      $display("FAIL ignore_bits got=%h want=%h", b, {2'b00, 1'b1, 8'h96, 1'b0});
    end
    go_to(200);
    total++;
    if (done_cnt - d0 !== 1 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_extra done=%0d busy=%b want=1/0", done_cnt - d0, o_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] b;
    logic        hi;
    int          d0;
    sel = 2'd0;
    adv(2);
    start_frame(8'hFF);
    go_to(4 * 16 + 8);
    d0 = done_cnt;
    #2;
    areset_n = 1'b0;
    #1;
    total++;
    if ({o_tx, o_busy, o_rdy, o_done} !== 4'b1010) begin
      bad++;
      $display("FAIL midrst_now got=%b want=1010", {o_tx, o_busy, o_rdy, o_done});
    end
    repeat (3) @(posedge clk);
    #1;
    areset_n = 1'b1;
    adv(200);
    total++;
    if (done_cnt !== d0 || o_busy !== 1'b0 || o_tx !== 1'b1) begin
      bad++;
      $display("FAIL midrst_after done=%0d busy=%b tx=%b want=%0d/0/1", done_cnt, o_busy, o_tx, d0);
    end
    d0 = done_cnt;
    start_frame(8'h3C);
    capture(10, 144, b, hi);
    total++;
    if (b !== {2'b00, 1'b1, 8'h3C, 1'b0} || hi !== 1'b1) begin
      bad++;
      $display("FAIL midrst_resend got=%h/%b want=%h/1", b, hi, {2'b00, 1'b1, 8'h3C, 1'b0});
    end
    go_to(160);
    total++;
    if (done_cnt - d0 !== 1 || o_rdy !== 1'b1) begin
      bad++;
      $display("FAIL midrst_resend_done done=%0d rdy=%b want=1/1", done_cnt - d0, o_rdy);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
